memorybank_arbiter: RTL
=======================

Name: memorybank_arbiter

Overview:
- Shares the single-port 64x16 node memory bank between two requesters.
- Requester 0 is the packet RX path, which writes neighbour/nodeID entries.
- Requester 1 is the RL update engine, which reads and writes Q/energy entries.
- Serialises accesses, arbitrates round-robin, drives the bank's wr_en/index/data_in port and returns read data with a fixed latency.

Parameters:
- WORD_WIDTH, 16, data width of a bank word.
- ADDR_WIDTH, 6, index width.
- MEM_DEPTH, 64, number of bank entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_wr  in  1  1 = write, 0 = read.
- req0_index  in  ADDR_WIDTH  target entry.
- req0_wdata  in  WORD_WIDTH  write data.
- rsp0_valid  out  1  one-cycle pulse; rsp0_rdata is valid.
- rsp0_rdata  out  WORD_WIDTH  read data.
- req1_valid, req1_ready, req1_wr, req1_index, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- mem_wr_en  out  1  bank write enable.
- mem_index  out  ADDR_WIDTH  bank index.
- mem_data_in  out  WORD_WIDTH  bank write data.
- mem_data_out  in  WORD_WIDTH  bank read data; valid one cycle after index is presented (synchronous read).
- busy  out  1  high while any access or clear sweep is in progress.

Behaviour:
- Reset (async, immediate):
  - state = IDLE (CLEAR if MEMBANK_CLR_EN).
  - All outputs 0; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP (+ CLEAR).
- IDLE:
  - readyN is combinational and is asserted for at most one requester.
  - Only one requester valid: it wins.
  - Both valid: the winner is the requester other than last_grant.
  - Handshake completes on validN & readyN at a rising edge. The edge latches wr, index, wdata and grant id, updates last_grant, and moves to ACCESS.
  - No valid: stay in IDLE, readies 0.
- ACCESS (exactly one cycle):
  - mem_index and mem_data_in are registered copies of the latched request.
  - mem_wr_en = latched wr.
  - Write: next state IDLE.
  - Read: next state RESP.
- RESP (one cycle):
  - mem_wr_en = 0, mem_index held.
  - At the edge ending RESP, mem_data_out is registered into rspN_rdata of the granted requester, and rspN_valid pulses for the next cycle.
  - Next state IDLE.
- Latency, with accept at edge T:
  - Write: mem_wr_en high in cycle T+1; a new accept is possible at edge T+2.
  - Read: rsp valid in cycle T+3, coinciding with IDLE, where a new request may be accepted in the same cycle.
- Response path:
  - No response backpressure; the requester must consume the rsp pulse.
  - rspN_rdata holds its value until the next read response to that requester.
- busy = (state != IDLE).
- readies are 0 in every state except IDLE.
- Request fields are sampled only at the accept edge; changes while not ready are ignored.
- Back-to-back, both requesters permanently valid: grants alternate 0,1,0,1…
- Reset asserted mid-access: the access is aborted and no response is issued. mem_wr_en drops asynchronously, so a partial write cannot be extended.
- Indices wrap naturally at ADDR_WIDTH; there is no out-of-range check.

Optional Feature:
- Macro: MEMBANK_CLR_EN.
- Defined:
  - After reset deassertion, the FSM enters CLEAR and sweeps index 0..MEM_DEPTH-1, one per cycle, with mem_wr_en=1 and mem_data_in=0.
  - busy=1 and both readies=0 during the sweep.
  - After index MEM_DEPTH-1 is written, go to IDLE: 64 cycles total, then mem_wr_en=0.
  - Reset during CLEAR restarts the sweep from 0.
- Undefined: reset goes directly to IDLE, and the bank contents are untouched.

Decomposition:
- Package memorybank_pkg: WORD_WIDTH, ADDR_WIDTH, MEM_DEPTH constants; state enum (IDLE, ACCESS, RESP, CLEAR).
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: valid0, valid1, last_grant, enable.
  - Outputs: one-hot grant.
  - Purely combinational; last_grant is stored in the parent.

Test Plan:
- Req0 write index=0 data=3, then req0 read index=0: mem_wr_en high for 1 cycle with mem_index=0 and mem_data_in=3; rsp0_valid pulses 3 cycles after the read accept with rsp0_rdata=3.
- Req1 write index=1 data=15, then req1 read index=1: rsp1_rdata=15; rsp0_valid stays 0 throughout.
- Both requesters valid every cycle for 4 requests each, writing distinct indices: grants alternate 0,1,0,1…, starting with 0; each write appears on the bank exactly once.
- Req0 read index=63 while req1 write index=63 data=0xFFFF, asserted together: req0 is served first and returns the old value; a subsequent read returns 0xFFFF.
- Assert rst during the ACCESS cycle of a write to index=5 data=9: mem_wr_en falls immediately, no rsp pulse occurs, and the FSM is in IDLE after release.
- With MEMBANK_CLR_EN: after reset release, 64 consecutive writes of 0 to indices 0..63; busy=1 and readies=0 for those 64 cycles; a read of index=10 afterwards returns 0.

Source files
------------

// File: rtl/memorybank_pkg.sv
// Shared constants and FSM state type for the node memory bank arbiter.
package memorybank_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 6;
    localparam int MEM_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        CLEAR
    } state_t;

endpackage

// File: rtl/memorybank_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, history kept by the parent.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            if (valid0 && (!valid1 || last_grant)) begin
                grant[0] = 1'b1;
            end else if (valid1) begin
                grant[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memorybank_arbiter.sv
// Serialises two requesters onto the single-port node memory bank (round-robin, fixed latency).
// Optional power-on clear sweep of the bank when MEMBANK_CLR_EN is defined.
module memorybank_arbiter
    import memorybank_pkg::*;
#(
    parameter int WORD_WIDTH = memorybank_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = memorybank_pkg::ADDR_WIDTH,
    parameter int MEM_DEPTH  = memorybank_pkg::MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_index,
    input  logic [WORD_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [WORD_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_index,
    input  logic [WORD_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [WORD_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_index,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    state_t                state;
    logic                  last_grant;
    logic                  gnt_id;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [1:0]            grant;
    logic                  arb_enable;

    assign arb_enable = (state == IDLE) && !rst;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .enable     (arb_enable),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

`ifdef MEMBANK_CLR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clearing;

    // Sweep outputs are gated by rst so the bank sees no writes while reset is held.
    assign clearing    = (state == CLEAR) && !rst;
    assign mem_wr_en   = wr_en_q | clearing;
    assign mem_index   = clearing ? clr_cnt : index_q;
    assign mem_data_in = clearing ? '0 : wdata_q;
    assign busy        = (state != IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`else
    assign mem_wr_en   = wr_en_q;
    assign mem_index   = index_q;
    assign mem_data_in = wdata_q;
    assign busy        = (state != IDLE);
`endif

    // wr_en_q doubles as the latched request type: it is only cleared at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef MEMBANK_CLR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            wr_en_q    <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        wr_en_q    <= grant[1] ? req1_wr    : req0_wr;
                        index_q    <= grant[1] ? req1_index : req0_index;
                        wdata_q    <= grant[1] ? req1_wdata : req0_wdata;
                        gnt_id     <= grant[1];
                        last_grant <= grant[1];
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    wr_en_q <= 1'b0;
                    state   <= wr_en_q ? IDLE : RESP;
                end
                RESP: begin
                    if (gnt_id) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= mem_data_out;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= mem_data_out;
                    end
                    state <= IDLE;
                end
                CLEAR: begin
`ifdef MEMBANK_CLR_EN
                    if (clr_cnt == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
